ram_wr_sched: RTL and testbench



---
 rtl/ram_wr_sched_pkg.sv | 34 +++
 rtl/ram_wr_sched_if.sv | 38 +++
 rtl/ram_wr_sched_pick.sv | 73 +++++++
 rtl/ram_wr_sched.sv | 134 +++++++++++++
 tb/tb_ram_wr_sched.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_wr_sched_pkg.sv
// ============================================================================
// Module      : ram_wr_sched_pkg
// Description : Shared types, widths and helpers for the RAM write scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_wr_sched_pkg;

  localparam int NUM_REQ_DEF = 8;
  localparam int NUM_WR_DEF  = 4;
  localparam int INDEX_DEF   = 4;
  localparam int WIDTH_DEF   = 8;
  localparam int PTR_W       = $clog2(NUM_REQ_DEF);

  // One write: a request lane or an output slot (valid doubles as we).
  typedef struct packed {
    logic                 valid;
    logic [INDEX_DEF-1:0] addr;
    logic [WIDTH_DEF-1:0] data;
  } wr_req_t;

  function automatic logic [31:0] popcount(input logic [31:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_wr_sched_if.sv
// ============================================================================
// Module      : ram_wr_sched_if
// Description : Request-lane valid/ready bundle between producers and the
//               write scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_wr_sched_if
  import ram_wr_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int INDEX   = INDEX_DEF,
  parameter int WIDTH   = WIDTH_DEF
);

  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*INDEX-1:0] req_addr_i;
  logic [NUM_REQ*WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]       req_ready_o;

  modport master (
    output req_valid_i,
    output req_addr_i,
    output req_data_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_addr_i,
    input  req_data_i,
    output req_ready_o
  );

endinterface

`default_nettype wire

// File: rtl/ram_wr_sched_pick.sv
// ============================================================================
// Module      : ram_wr_sched_pick
// Description : Combinational rotating-priority scan with address-conflict
//               masking; yields grants, slot per lane and the next pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_wr_sched_pick
  import ram_wr_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int NUM_WR  = NUM_WR_DEF,
  parameter int INDEX   = INDEX_DEF,
  parameter int SLOT_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
  input  wire logic                      i_block,
  input  wire logic [NUM_REQ-1:0]        i_valid,
  input  wire logic [NUM_REQ*INDEX-1:0]  i_addr,
  input  wire logic [PTR_W-1:0]          i_ptr,
  output logic      [NUM_REQ-1:0]        o_grant,
  output logic      [NUM_REQ*SLOT_W-1:0] o_slot,
  output logic                           o_any_deny,
  output logic      [PTR_W-1:0]          o_ptr_nxt
);

  logic [NUM_REQ-1:0]        w_grant;
  logic [NUM_REQ*SLOT_W-1:0] w_slot;
  logic [PTR_W-1:0]          w_lane;
  logic [PTR_W-1:0]          w_first_deny;
  logic                      w_deny;
  logic                      w_conflict;
  int                        w_n_granted;

  always_comb begin
    w_grant      = '0;
    w_slot       = '0;
    w_lane       = '0;
    w_first_deny = '0;
    w_deny       = 1'b0;
    w_conflict   = 1'b0;
    w_n_granted  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_lane     = i_ptr + PTR_W'(i);
      w_conflict = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (w_grant[j] && (i_addr[j*INDEX +: INDEX] == i_addr[w_lane*INDEX +: INDEX])) begin
          w_conflict = 1'b1;
        end
      end
      if (i_valid[w_lane] && !i_block) begin
        if ((w_n_granted < NUM_WR) && !w_conflict) begin
          w_grant[w_lane]                  = 1'b1;
          w_slot[w_lane*SLOT_W +: SLOT_W]  = SLOT_W'(w_n_granted);
          w_n_granted                      = w_n_granted + 1;
        end else if (!w_deny) begin
          // Oldest loser in scan order leads next cycle so it cannot starve.
          w_deny       = 1'b1;
          w_first_deny = w_lane;
        end
      end
    end
  end

  assign o_grant    = w_grant;
  assign o_slot     = w_slot;
  assign o_any_deny = w_deny;
  assign o_ptr_nxt  = w_deny        ? w_first_deny :
                      (|w_grant)    ? i_ptr + PTR_W'(1) : i_ptr;

endmodule

`default_nettype wire

// File: rtl/ram_wr_sched.sv
// ============================================================================
// Module      : ram_wr_sched
// Description : Write-side scheduler for the multi-ported register RAM;
//               grants up to NUM_WR conflict-free lanes per cycle into a
//               registered write-port stage. Optional RAM_WR_SCHED_STATS_EN
//               adds saturating issue/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_wr_sched
  import ram_wr_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int NUM_WR  = NUM_WR_DEF,
  parameter int INDEX   = INDEX_DEF,
  parameter int WIDTH   = WIDTH_DEF
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  input  wire logic                    flush_i,
  ram_wr_sched_if.slave                req,
  output logic [NUM_WR-1:0]            we_o,
  output logic [NUM_WR*INDEX-1:0]      addrwr_o,
  output logic [NUM_WR*WIDTH-1:0]      datawr_o,
  output logic                         stall_o
`ifdef RAM_WR_SCHED_STATS_EN
  ,
  output logic [31:0]                  stat_issued_o,
  output logic [31:0]                  stat_stall_o
`endif
);

  localparam int SLOT_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  logic [PTR_W-1:0]          ptr_q, ptr_d;
  wr_req_t                   slot_q [NUM_WR];
  wr_req_t                   slot_d [NUM_WR];
  logic                      stall_q, stall_d;

  logic [NUM_REQ-1:0]        w_grant;
  logic [NUM_REQ*SLOT_W-1:0] w_slot;
  logic                      w_any_deny;
  logic [PTR_W-1:0]          w_ptr_nxt;
  logic                      w_block;

  assign w_block = reset | flush_i;

  ram_wr_sched_pick #(
    .NUM_REQ (NUM_REQ),
    .NUM_WR  (NUM_WR),
    .INDEX   (INDEX),
    .SLOT_W  (SLOT_W)
  ) u_pick (
    .i_block    (w_block),
    .i_valid    (req.req_valid_i),
    .i_addr     (req.req_addr_i),
    .i_ptr      (ptr_q),
    .o_grant    (w_grant),
    .o_slot     (w_slot),
    .o_any_deny (w_any_deny),
    .o_ptr_nxt  (w_ptr_nxt)
  );

  assign req.req_ready_o = w_grant;

  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      slot_d[j] = '0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        slot_d[w_slot[k*SLOT_W +: SLOT_W]].valid = 1'b1;
        slot_d[w_slot[k*SLOT_W +: SLOT_W]].addr  = req.req_addr_i[k*INDEX +: INDEX];
        slot_d[w_slot[k*SLOT_W +: SLOT_W]].data  = req.req_data_i[k*WIDTH +: WIDTH];
      end
    end
    // A flushed cycle says nothing about contention, so stall holds.
    stall_d = flush_i ? stall_q : w_any_deny;
    ptr_d   = w_ptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      stall_q <= 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        slot_q[j] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      for (int j = 0; j < NUM_WR; j++) begin
        slot_q[j] <= slot_d[j];
      end
    end
  end

  for (genvar j = 0; j < NUM_WR; j++) begin : g_out
    assign we_o[j]                   = slot_q[j].valid;
    assign addrwr_o[j*INDEX +: INDEX] = slot_q[j].addr;
    assign datawr_o[j*WIDTH +: WIDTH] = slot_q[j].data;
  end

  assign stall_o = stall_q;

`ifdef RAM_WR_SCHED_STATS_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] stat_stall_q, stat_stall_d;
  logic [32:0] w_issued_sum;

  always_comb begin
    w_issued_sum = {1'b0, issued_q} + {1'b0, popcount(32'(we_o))};
    issued_d     = w_issued_sum[32] ? '1 : w_issued_sum[31:0];
    stat_stall_d = (stall_q && (stat_stall_q != '1)) ? stat_stall_q + 32'd1 : stat_stall_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q     <= '0;
      stat_stall_q <= '0;
    end else begin
      issued_q     <= issued_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_issued_o = issued_q;
  assign stat_stall_o  = stat_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_wr_sched.sv
// ============================================================================
// Module      : tb_ram_wr_sched
// Description : Scenario bench for ram_wr_sched with an expected-output queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_wr_sched;

  typedef struct packed {
    logic [3:0]  we;
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [3:0]  dut_we;
  logic [15:0] dut_addr;
  logic [31:0] dut_data;
  logic        dut_stall;
`ifdef RAM_WR_SCHED_STATS_EN
  logic [31:0] dut_stat_issued;
  logic [31:0] dut_stat_stall;
`endif

  exp_t exp_q[$];
  exp_t e;
  int   n_checks;
  int   n_pass;

  ram_wr_sched_if u_if ();

  ram_wr_sched u_dut (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush),
    .req      (u_if),
    .we_o     (dut_we),
    .addrwr_o (dut_addr),
    .datawr_o (dut_data),
    .stall_o  (dut_stall)
`ifdef RAM_WR_SCHED_STATS_EN
    ,
    .stat_issued_o (dut_stat_issued),
    .stat_stall_o  (dut_stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t act_out();
    return {dut_we, dut_addr, dut_data};
  endfunction

  task automatic push_exp(input logic [3:0] we, input logic [15:0] a, input logic [31:0] d);
    exp_q.push_back({we, a, d});
  endtask

  task automatic set_lane(input int k, input logic [3:0] a, input logic [7:0] d);
    u_if.req_valid_i[k]       = 1'b1;
    u_if.req_addr_i[k*4 +: 4] = a;
    u_if.req_data_i[k*8 +: 8] = d;
  endtask

  task automatic drop_lane(input int k);
    u_if.req_valid_i[k] = 1'b0;
  endtask

  task automatic clear_lanes();
    u_if.req_valid_i = '0;
    u_if.req_addr_i  = '0;
    u_if.req_data_i  = '0;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    clear_lanes();
    next_edge();
    next_edge();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_lane(0, 4'd1, 8'h11);
    set_lane(1, 4'd2, 8'h22);
    #1;
    n_checks++;
    if (u_if.req_ready_o !== 8'h00) $display("FAIL reset_ready got %h want %h", u_if.req_ready_o, 8'h00);
    else n_pass++;
    push_exp(4'h0, 16'h0, 32'h0);
    next_edge();
    e = exp_q.pop_front();
    n_checks++;
    if (act_out() !== e) $display("FAIL reset_out got %h want %h", act_out(), e);
    else n_pass++;
    n_checks++;
    if (dut_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", dut_stall);
    else n_pass++;
    clear_lanes();
    next_edge();
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    set_lane(2, 4'd5, 8'hAA);
    #1;
    n_checks++;
    if (u_if.req_ready_o !== 8'h04) $display("FAIL single_ready got %h want %h", u_if.req_ready_o, 8'h04);
    else n_pass++;
    push_exp(4'b0001, 16'h0005, 32'h0000_00AA);
    next_edge();
    e = exp_q.pop_front();
    n_checks++;
    if (act_out() !== e) $display("FAIL single_out got %h want %h", act_out(), e);
    else n_pass++;
    drop_lane(2);
    push_exp(4'b0000, 16'h0, 32'h0);
    next_edge();
    e = exp_q.pop_front();
    n_checks++;
    if (act_out() !== e) $display("FAIL single_idle got %h want %h", act_out(), e);
    else n_pass++;
  endtask

  task automatic test_oversub();
    do_reset();
    for (int k = 0; k < 8; k++) set_lane(k, 4'(k), 8'(8'h10 + k));
    #1;
    n_checks++;
    if (u_if.req_ready_o !== 8'h0F) $display("FAIL oversub_ready0 got %h want %h", u_if.req_ready_o, 8'h0F);
    else n_pass++;
    push_exp(4'hF, 16'h3210, 32'h1312_1110);
    next_edge();
    e = exp_q.pop_front();
    n_checks++;
    if (act_out() !== e) $display("FAIL oversub_out0 got %h want %h", act_out(), e);
    else n_pass++;
    n_checks++;
    if (dut_stall !== 1'b1) $display("FAIL oversub_stall got %b want 1", dut_stall);
    else n_pass++;
    for (int k = 0; k < 4; k++) drop_lane(k);
    #1;
    n_checks++;
    if (u_if.req_ready_o !== 8'hF0) $display("FAIL oversub_ready1 got %h want %h", u_if.req_ready_o, 8'hF0);
    else n_pass++;
    push_exp(4'hF, 16'h7654, 32'h1716_1514);
    next_edge();
    e = exp_q.pop_front();
    n_checks++;
    if (act_out() !== e) $display("FAIL oversub_out1 got %h want %h", act_out(), e);
    else n_pass++;
    n_checks++;
    if (dut_stall !== 1'b0) $display("FAIL oversub_stall_clr got %b want 0", dut_stall);
    else n_pass++;
    clear_lanes();
  endtask

  task automatic test_conflict();
    do_reset();
    set_lane(0, 4'd3, 8'h31);
    set_lane(1, 4'd3, 8'h32);
    #1;
    n_checks++;
    if (u_if.req_ready_o !== 8'h01) $display("FAIL conflict_ready0 got %h want %h", u_if.req_ready_o, 8'h01);
    else n_pass++;
    push_exp(4'b0001, 16'h0003, 32'h0000_0031);
    next_edge();
    e = exp_q.pop_front();
    n_checks++;
    if (act_out() !== e) $display("FAIL conflict_out0 got %h want %h", act_out(), e);
    else n_pass++;
    drop_lane(0);
    #1;
    n_checks++;
    if (u_if.req_ready_o !== 8'h02) $display("FAIL conflict_ready1 got %h want %h", u_if.req_ready_o, 8'h02);
    else n_pass++;
    push_exp(4'b0001, 16'h0003, 32'h0000_0032);
    next_edge();
    e = exp_q.pop_front();
    n_checks++;
    if (act_out() !== e) $display("FAIL conflict_out1 got %h want %h", act_out(), e);
    else n_pass++;
    clear_lanes();
  endtask

  task automatic test_wrap();
    do_reset();
    // Lane 6 is the only loser, which moves the pointer to 6.
    for (int k = 0; k < 4; k++) set_lane(k, 4'(k), 8'(8'hA0 + k));
    set_lane(6, 4'd6, 8'hA6);
    #1;
    n_checks++;
    if (u_if.req_ready_o !== 8'h0F) $display("FAIL wrap_ready0 got %h want %h", u_if.req_ready_o, 8'h0F);
    else n_pass++;
    push_exp(4'hF, 16'h3210, 32'hA3A2_A1A0);
    next_edge();
    e = exp_q.pop_front();
    n_checks++;
    if (act_out() !== e) $display("FAIL wrap_out0 got %h want %h", act_out(), e);
    else n_pass++;
    for (int k = 0; k < 4; k++) drop_lane(k);
    set_lane(7, 4'd7, 8'hB7);
    set_lane(0, 4'd0, 8'hB0);
    set_lane(1, 4'd1, 8'hB1);
    set_lane(2, 4'd2, 8'hB2);
    #1;
    n_checks++;
    if (u_if.req_ready_o !== 8'hC3) $display("FAIL wrap_ready1 got %h want %h", u_if.req_ready_o, 8'hC3);
    else n_pass++;
    push_exp(4'hF, 16'h1076, 32'hB1B0_B7A6);
    next_edge();
    e = exp_q.pop_front();
    n_checks++;
    if (act_out() !== e) $display("FAIL wrap_out1 got %h want %h", act_out(), e);
    else n_pass++;
    n_checks++;
    if (dut_stall !== 1'b1) $display("FAIL wrap_stall got %b want 1", dut_stall);
    else n_pass++;
    drop_lane(6);
    drop_lane(7);
    drop_lane(1);
    set_lane(0, 4'd8, 8'hC0);
    set_lane(3, 4'd3, 8'hC3);
    set_lane(4, 4'd4, 8'hC4);
    set_lane(5, 4'd5, 8'hC5);
    #1;
    n_checks++;
    if (u_if.req_ready_o !== 8'h3C) $display("FAIL wrap_ready2 got %h want %h", u_if.req_ready_o, 8'h3C);
    else n_pass++;
    push_exp(4'hF, 16'h5432, 32'hC5C4_C3B2);
    next_edge();
    e = exp_q.pop_front();
    n_checks++;
    if (act_out() !== e) $display("FAIL wrap_out2 got %h want %h", act_out(), e);
    else n_pass++;
    clear_lanes();
  endtask

  task automatic test_flush_reset();
    do_reset();
    for (int k = 0; k < 5; k++) set_lane(k, 4'(k), 8'(8'h40 + k));
    push_exp(4'hF, 16'h3210, 32'h4342_4140);
    next_edge();
    e = exp_q.pop_front();
    n_checks++;
    if (act_out() !== e) $display("FAIL flush_pre got %h want %h", act_out(), e);
    else n_pass++;
    for (int k = 0; k < 4; k++) drop_lane(k);
    flush = 1'b1;
    #1;
    n_checks++;
    if (u_if.req_ready_o !== 8'h00) $display("FAIL flush_ready got %h want %h", u_if.req_ready_o, 8'h00);
    else n_pass++;
    push_exp(4'h0, 16'h0, 32'h0);
    next_edge();
    e = exp_q.pop_front();
    n_checks++;
    if (act_out() !== e) $display("FAIL flush_out got %h want %h", act_out(), e);
    else n_pass++;
    n_checks++;
    if (dut_stall !== 1'b1) $display("FAIL flush_stall_hold got %b want 1", dut_stall);
    else n_pass++;
    flush = 1'b0;
    set_lane(0, 4'd9, 8'h50);
    #1;
    n_checks++;
    if (u_if.req_ready_o !== 8'h11) $display("FAIL flush_ptr_ready got %h want %h", u_if.req_ready_o, 8'h11);
    else n_pass++;
    push_exp(4'b0011, 16'h0094, 32'h0000_5044);
    next_edge();
    e = exp_q.pop_front();
    n_checks++;
    if (act_out() !== e) $display("FAIL flush_post got %h want %h", act_out(), e);
    else n_pass++;
    clear_lanes();
    for (int k = 0; k < 4; k++) set_lane(k, 4'(k), 8'(8'h60 + k));
    push_exp(4'hF, 16'h3210, 32'h6362_6160);
    next_edge();
    e = exp_q.pop_front();
    n_checks++;
    if (act_out() !== e) $display("FAIL midrst_pre got %h want %h", act_out(), e);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if (u_if.req_ready_o !== 8'h00) $display("FAIL midrst_ready got %h want %h", u_if.req_ready_o, 8'h00);
    else n_pass++;
    push_exp(4'h0, 16'h0, 32'h0);
    next_edge();
    e = exp_q.pop_front();
    n_checks++;
    if (act_out() !== e) $display("FAIL midrst_out got %h want %h", act_out(), e);
    else n_pass++;
    reset = 1'b0;
    clear_lanes();
    // Pointer 0 grants 0,4,5,6 and denies 7; a stale pointer of 6 would not.
    for (int k = 4; k < 8; k++) set_lane(k, 4'(k), 8'(8'h70 + k));
    set_lane(0, 4'd0, 8'h70);
    #1;
    n_checks++;
    if (u_if.req_ready_o !== 8'h71) $display("FAIL midrst_ptr got %h want %h", u_if.req_ready_o, 8'h71);
    else n_pass++;
    clear_lanes();
  endtask

`ifdef RAM_WR_SCHED_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 8; k++) set_lane(k, 4'(k), 8'(8'h10 + k));
    next_edge();
    for (int k = 0; k < 4; k++) drop_lane(k);
    next_edge();
    clear_lanes();
    next_edge();
    n_checks++;
    if (dut_stat_issued !== 32'd8) $display("FAIL stats_issued got %0d want 8", dut_stat_issued);
    else n_pass++;
    n_checks++;
    if (dut_stat_stall !== 32'd1) $display("FAIL stats_stall got %0d want 1", dut_stat_stall);
    else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    flush    = 1'b0;
    clear_lanes();
    test_reset();
    test_single();
    test_oversub();
    test_conflict();
    test_wrap();
    test_flush_reset();
`ifdef RAM_WR_SCHED_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
